// File: rtl/uart_result_pkg.sv
// uart_result_pkg
//   Shared definitions for the detection-result frame carried over the UART
//   link. Both this parser and the UART sender framer import it, so the
//   header byte, payload length, status bit layout and the decoded result
//   record stay identical on both ends of the link.
//   Frame on the wire: AA | x_min | x_max | y_min | y_max | status | csum
//   (coordinates 16 bit, MSB first; csum is the XOR of every byte between
//   the header and the checksum).
package uart_result_pkg;

  localparam logic [7:0] HDR_BYTE    = 8'hAA;
  localparam int         PAYLOAD_LEN = 9;
  localparam int         STATUS_IDX  = PAYLOAD_LEN - 1;

  // Bit positions inside the status byte
  localparam int ST_LIGHT_BIT  = 0;
  localparam int ST_HUMAN_LSB  = 1;
  localparam int ST_CAR_BIT    = 3;
  localparam int ST_AMOUNT_LSB = 4;
  localparam int ST_RSVD_LSB   = 6;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } parse_state_t;

  // Payload bytes in arrival order: index 0 is x_min MSB, STATUS_IDX is status
  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef struct packed {
    logic [15:0] x_min;
    logic [15:0] x_max;
    logic [15:0] y_min;
    logic [15:0] y_max;
    logic        traffic_light;
    logic [1:0]  human_violation;
    logic        car_violation;
    logic [1:0]  traffic_amount;
  } result_t;

  // Splits the collected payload into the decoded result record
  function automatic result_t unpack_result(input payload_t p);
    result_t r;
    r.x_min           = {p[0], p[1]};
    r.x_max           = {p[2], p[3]};
    r.y_min           = {p[4], p[5]};
    r.y_max           = {p[6], p[7]};
    r.traffic_light   = p[STATUS_IDX][ST_LIGHT_BIT];
    r.human_violation = p[STATUS_IDX][ST_HUMAN_LSB +: 2];
    r.car_violation   = p[STATUS_IDX][ST_CAR_BIT];
    r.traffic_amount  = p[STATUS_IDX][ST_AMOUNT_LSB +: 2];
    return r;
  endfunction

  // Code 3 is unused for the two-bit fields and the top two bits are reserved
  function automatic logic status_legal(input logic [7:0] status);
    return (status[ST_HUMAN_LSB +: 2]  != 2'd3) &&
           (status[ST_AMOUNT_LSB +: 2] != 2'd3) &&
           (status[ST_RSVD_LSB +: 2]   == 2'd0);
  endfunction

endpackage

// File: rtl/uart_result_parser_if.sv
// uart_result_parser_if
//   Byte stream from the UART receive FIFO into the result parser.
//   rx_valid : one-cycle pop strobe, rx_data holds a received byte
//   rx_data  : received byte
//   master   : the UART receive side driving the stream
//   slave    : the parser consuming it
interface uart_result_parser_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/rx_timeout_timer.sv
// rx_timeout_timer
//   Saturating cycle counter that flags when CYCLES-1 cycles have passed
//   since the last clear. Used for the inter-byte timeout and for the
//   stale-data indicator.
//   clk, reset : system clock, asynchronous active-high reset
//   clear_i    : restart the count from zero (wins over enable_i)
//   enable_i   : count this cycle
//   expire_o   : count has reached CYCLES-1; holds there until cleared
//   START_EXPIRED selects whether reset leaves the timer already expired.
module rx_timeout_timer #(
  parameter int CYCLES        = 16,
  parameter bit START_EXPIRED = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int           W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Count up while enabled, stopping at LAST so the expire flag stays high
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= START_EXPIRED ? LAST : '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/uart_result_parser.sv
// uart_result_parser
//   Decodes 11-byte detection-result frames from the UART receive stream
//   and holds the last good frame's fields for the VGA overlay and the
//   controller logic.
//   clk, reset          : system clock, asynchronous active-high reset
//   rx_if (slave)       : rx_valid strobe + rx_data byte
//   x_min_o .. y_max_o  : bounding-box limits of the last good frame
//   traffic_light_o     : 0 green, 1 red
//   human_violation_o   : 0 none, 1 caution, 2 violation
//   car_violation_o     : 0 none, 1 violation
//   traffic_amount_o    : 0 low, 1 medium, 2 high
//   frame_valid_o       : one-cycle pulse, field outputs just updated
//   frame_err_o         : one-cycle pulse, frame rejected (checksum, range, timeout)
//   err_count_o         : saturating count of rejected frames
//   data_stale_o        : no good frame within STALE_CYC cycles
module uart_result_parser
  import uart_result_pkg::*;
#(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int STALE_CYC   = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_result_parser_if.slave  rx_if,
  output logic [15:0]          x_min_o,
  output logic [15:0]          x_max_o,
  output logic [15:0]          y_min_o,
  output logic [15:0]          y_max_o,
  output logic                 traffic_light_o,
  output logic [1:0]           human_violation_o,
  output logic                 car_violation_o,
  output logic [1:0]           traffic_amount_o,
  output logic                 frame_valid_o,
  output logic                 frame_err_o,
  output logic [7:0]           err_count_o,
  output logic                 data_stale_o
);

  localparam logic [15:0] X_LIMIT  = 16'(H_RES);
  localparam logic [15:0] Y_LIMIT  = 16'(V_RES);
  localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_LEN - 1);

  parse_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  payload_t     payload_q, payload_d;
  result_t      result_q, result_d;
  logic         frame_valid_q, frame_valid_d;
  logic         frame_err_q, frame_err_d;
  logic [7:0]   err_count_q, err_count_d;

  logic         reject;
  logic         byte_timeout;
  logic         in_frame;
  logic         byte_timer_clear;
  result_t      candidate;
  logic         frame_ok;

  assign in_frame         = (state_q != IDLE);
  assign byte_timer_clear = rx_if.rx_valid || !in_frame;

  // Inter-byte watchdog: only runs while a frame is being collected and
  // restarts on every received byte.
  rx_timeout_timer #(
    .CYCLES        (TIMEOUT_CYC),
    .START_EXPIRED (1'b0)
  ) u_byte_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (byte_timer_clear),
    .enable_i (in_frame),
    .expire_o (byte_timeout)
  );

  // Stale indicator: starts expired so the outputs read as stale until the
  // first good frame lands.
  rx_timeout_timer #(
    .CYCLES        (STALE_CYC),
    .START_EXPIRED (1'b1)
  ) u_stale_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (frame_valid_q),
    .enable_i (1'b1),
    .expire_o (data_stale_o)
  );

  // In CHECK the payload is complete, so the whole frame can be judged
  // against the checksum byte currently on rx_data.
  assign candidate = unpack_result(payload_q);
  assign frame_ok  = (rx_if.rx_data == csum_q) &&
                     (candidate.x_min <= candidate.x_max) &&
                     (candidate.x_max <  X_LIMIT) &&
                     (candidate.y_min <= candidate.y_max) &&
                     (candidate.y_max <  Y_LIMIT) &&
                     status_legal(payload_q[STATUS_IDX]);

  // Frame parser. A byte arriving in the same cycle the watchdog expires is
  // still taken, which is why rx_valid is tested before byte_timeout. A
  // header byte seen mid-frame is ordinary data: there is no resync.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    payload_d     = payload_q;
    result_d      = result_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_count_d   = err_count_q;
    reject        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_if.rx_valid && (rx_if.rx_data == HDR_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end

      PAYLOAD: begin
        if (rx_if.rx_valid) begin
          payload_d[idx_q] = rx_if.rx_data;
          csum_d           = csum_q ^ rx_if.rx_data;
          idx_d            = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end
        end else if (byte_timeout) begin
          state_d = IDLE;
          reject  = 1'b1;
        end
      end

      CHECK: begin
        if (rx_if.rx_valid) begin
          state_d = IDLE;
          if (frame_ok) begin
            result_d      = candidate;
            frame_valid_d = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end else if (byte_timeout) begin
          state_d = IDLE;
          reject  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reject) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // Parser state and result registers; reset drops any partial frame
  // without flagging it as an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      csum_q        <= '0;
      payload_q     <= '0;
      result_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      payload_q     <= payload_d;
      result_q      <= result_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign x_min_o           = result_q.x_min;
  assign x_max_o           = result_q.x_max;
  assign y_min_o           = result_q.y_min;
  assign y_max_o           = result_q.y_max;
  assign traffic_light_o   = result_q.traffic_light;
  assign human_violation_o = result_q.human_violation;
  assign car_violation_o   = result_q.car_violation;
  assign traffic_amount_o  = result_q.traffic_amount;
  assign frame_valid_o     = frame_valid_q;
  assign frame_err_o       = frame_err_q;
  assign err_count_o       = err_count_q;

endmodule

// File: tb/tb_uart_result_parser.sv
// tb_uart_result_parser
//   Drives frames byte by byte into uart_result_parser and compares its
//   outputs against a frame-level reference model kept in this bench.
module tb_uart_result_parser;

  localparam int TMO   = 16;
  localparam int STALE = 400;
  localparam int HRES  = 320;
  localparam int VRES  = 240;

  typedef logic [10:0][7:0] frameT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_min_o, x_max_o, y_min_o, y_max_o;
  logic        traffic_light_o;
  logic [1:0]  human_violation_o;
  logic        car_violation_o;
  logic [1:0]  traffic_amount_o;
  logic        frame_valid_o, frame_err_o;
  logic [7:0]  err_count_o;
  logic        data_stale_o;

  uart_result_parser_if rx_if();

  uart_result_parser #(
    .H_RES       (HRES),
    .V_RES       (VRES),
    .TIMEOUT_CYC (TMO),
    .STALE_CYC   (STALE)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rx_if             (rx_if),
    .x_min_o           (x_min_o),
    .x_max_o           (x_max_o),
    .y_min_o           (y_min_o),
    .y_max_o           (y_max_o),
    .traffic_light_o   (traffic_light_o),
    .human_violation_o (human_violation_o),
    .car_violation_o   (car_violation_o),
    .traffic_amount_o  (traffic_amount_o),
    .frame_valid_o     (frame_valid_o),
    .frame_err_o       (frame_err_o),
    .err_count_o       (err_count_o),
    .data_stale_o      (data_stale_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fvCount = 0;
  int feCount = 0;

  // Reference model state: what the outputs should show right now
  logic [15:0] expXmin, expXmax, expYmin, expYmax;
  logic        expLight, expCar;
  logic [1:0]  expHuman, expAmount;
  int          expErrCount;

  // Tally every pulse so that extra or missing pulses show up
  always @(negedge clk) begin
    if (frame_valid_o === 1'b1) fvCount <= fvCount + 1;
    if (frame_err_o === 1'b1)   feCount <= feCount + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    tick();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'($urandom);
  endtask

  function automatic frameT makeFrame(input logic [15:0] xa, input logic [15:0] xb,
                                      input logic [15:0] ya, input logic [15:0] yb,
                                      input logic [7:0] st);
    frameT f;
    f[0]  = 8'hAA;
    f[1]  = xa[15:8]; f[2] = xa[7:0];
    f[3]  = xb[15:8]; f[4] = xb[7:0];
    f[5]  = ya[15:8]; f[6] = ya[7:0];
    f[7]  = yb[15:8]; f[8] = yb[7:0];
    f[9]  = st;
    f[10] = 8'h00;
    for (int i = 1; i <= 9; i++) f[10] = f[10] ^ f[i];
    return f;
  endfunction

  // Frame-level acceptance rule: checksum, coordinate ranges, status codes
  function automatic bit modelAccept(input frameT f);
    logic [7:0]  c;
    logic [15:0] xa, xb, ya, yb;
    logic [7:0]  st;
    c = 8'h00;
    for (int i = 1; i <= 9; i++) c = c ^ f[i];
    xa = {f[1], f[2]};
    xb = {f[3], f[4]};
    ya = {f[5], f[6]};
    yb = {f[7], f[8]};
    st = f[9];
    return (f[10] == c) && (xa <= xb) && (xb < 16'(HRES)) &&
           (ya <= yb) && (yb < 16'(VRES)) &&
           (st[2:1] != 2'd3) && (st[5:4] != 2'd3) && (st[7:6] == 2'd0);
  endfunction

  task automatic modelApply(input bit acc, input frameT f);
    logic [7:0] st;
    st = f[9];
    if (acc) begin
      expXmin   = {f[1], f[2]};
      expXmax   = {f[3], f[4]};
      expYmin   = {f[5], f[6]};
      expYmax   = {f[7], f[8]};
      expLight  = st[0];
      expHuman  = st[2:1];
      expCar    = st[3];
      expAmount = st[5:4];
    end else begin
      expErrCount = (expErrCount < 255) ? expErrCount + 1 : 255;
    end
  endtask

  task automatic modelReset();
    expXmin = '0; expXmax = '0; expYmin = '0; expYmax = '0;
    expLight = 1'b0; expHuman = 2'd0; expCar = 1'b0; expAmount = 2'd0;
    expErrCount = 0;
  endtask

  task automatic checkFields(input string tag);
    checkOutput({tag, ".x_min"},  32'(x_min_o),           32'(expXmin));
    checkOutput({tag, ".x_max"},  32'(x_max_o),           32'(expXmax));
    checkOutput({tag, ".y_min"},  32'(y_min_o),           32'(expYmin));
    checkOutput({tag, ".y_max"},  32'(y_max_o),           32'(expYmax));
    checkOutput({tag, ".light"},  32'(traffic_light_o),   32'(expLight));
    checkOutput({tag, ".human"},  32'(human_violation_o), 32'(expHuman));
    checkOutput({tag, ".car"},    32'(car_violation_o),   32'(expCar));
    checkOutput({tag, ".amount"}, 32'(traffic_amount_o),  32'(expAmount));
    checkOutput({tag, ".errcnt"}, 32'(err_count_o),       32'(expErrCount));
  endtask

  // Sends a whole frame with 'gap' idle cycles between bytes, then checks
  // the pulse and fields in the cycle right after the checksum byte.
  task automatic sendFrame(input frameT f, input int gap, input string tag);
    int fv0, fe0;
    bit acc;
    fv0 = fvCount;
    fe0 = feCount;
    acc = modelAccept(f);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(f[i]);
      if (i < 10) repeat (gap) tick();
    end
    checkOutput({tag, ".valid"}, 32'(frame_valid_o), 32'(acc));
    checkOutput({tag, ".err"},   32'(frame_err_o),   32'(!acc));
    modelApply(acc, f);
    checkFields(tag);
    tick();
    checkOutput({tag, ".nvalid"}, fvCount - fv0, 32'(acc));
    checkOutput({tag, ".nerr"},   feCount - fe0, 32'(!acc));
    if (acc) checkOutput({tag, ".fresh"}, 32'(data_stale_o), 32'd0);
  endtask

  initial begin
    frameT good, f;
    int fv0, fe0;
    logic [15:0] xa, xb, ya, yb;
    logic [7:0]  st;

    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    modelReset();

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    checkFields("reset");
    checkOutput("reset.valid", 32'(frame_valid_o), 32'd0);
    checkOutput("reset.err",   32'(frame_err_o),   32'd0);
    checkOutput("reset.stale", 32'(data_stale_o),  32'd1);
    reset = 1'b0;
    tick();

    // Reference good frame: x 1..240, y 111..200, status 0x23
    good = makeFrame(16'd1, 16'd240, 16'd111, 16'd200, 8'h23);
    sendFrame(good, 0, "good");
    checkOutput("good.x_max_lit", 32'(x_max_o), 32'd240);
    checkOutput("good.amount_lit", 32'(traffic_amount_o), 32'd2);

    // Corrupted checksum
    f = good;
    f[10] = f[10] ^ 8'h01;
    sendFrame(f, 1, "badcsum");
    checkOutput("badcsum.errcnt_lit", 32'(err_count_o), 32'd1);

    // Range violations
    sendFrame(makeFrame(16'd1, 16'h0140, 16'd111, 16'd200, 8'h23), 0, "xmax320");
    sendFrame(makeFrame(16'd250, 16'd240, 16'd111, 16'd200, 8'h23), 0, "xmin_gt");
    sendFrame(makeFrame(16'd0, 16'd319, 16'd0, 16'd239, 8'h00), 0, "edges");
    sendFrame(makeFrame(16'd5, 16'd6, 16'd5, 16'd240, 8'h00), 0, "ymax240");
    sendFrame(makeFrame(16'd5, 16'd6, 16'd5, 16'd6, 8'h06), 0, "human3");
    sendFrame(makeFrame(16'd5, 16'd6, 16'd5, 16'd6, 8'h40), 0, "rsvd");

    // Stall after byte 5: error exactly TMO cycles after that byte
    fe0 = feCount;
    for (int i = 0; i <= 5; i++) applyStimulus(good[i]);
    repeat (TMO - 1) tick();
    checkOutput("tmo.before", 32'(frame_err_o), 32'd0);
    tick();
    checkOutput("tmo.err", 32'(frame_err_o), 32'd1);
    expErrCount = (expErrCount < 255) ? expErrCount + 1 : 255;
    checkOutput("tmo.errcnt", 32'(err_count_o), 32'(expErrCount));
    tick();
    checkOutput("tmo.nerr", feCount - fe0, 32'd1);
    sendFrame(good, 0, "aftertmo");

    // Every byte lands on the last cycle before the timeout
    sendFrame(makeFrame(16'd10, 16'd20, 16'd30, 16'd40, 8'h1B), TMO - 1, "tmoedge");

    // Garbage before the header is discarded silently
    fv0 = fvCount;
    fe0 = feCount;
    applyStimulus(8'h55);
    applyStimulus(8'h12);
    tick();
    checkOutput("garbage.pulses", (fvCount - fv0) + (feCount - fe0), 32'd0);

    // Header value appearing as payload data
    sendFrame(makeFrame(16'h00AA, 16'h00F0, 16'h00AA, 16'h00C8, 8'h15), 0, "aapayload");

    // Stale flag rises exactly STALE cycles after the frame_valid pulse
    repeat (STALE - 2) tick();
    checkOutput("stale.before", 32'(data_stale_o), 32'd0);
    tick();
    checkOutput("stale.after", 32'(data_stale_o), 32'd1);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      xa = 16'($urandom_range(0, 330));
      xb = xa + 16'($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) xb = 16'($urandom_range(0, 330));
      ya = 16'($urandom_range(0, 250));
      yb = ya + 16'($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) yb = 16'($urandom_range(0, 250));
      st = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) st = st & 8'h3F;
      f = makeFrame(xa, xb, ya, yb, st);
      if ($urandom_range(0, 5) == 0) f[10] = f[10] ^ 8'(1 << $urandom_range(0, 7));
      sendFrame(f, int'($urandom_range(0, 3)), "rand");
    end

    // Saturation of the error counter
    f = good;
    f[10] = f[10] ^ 8'h80;
    for (int n = 0; n < 300; n++) sendFrame(f, 0, "sat");
    checkOutput("sat.errcnt_lit", 32'(err_count_o), 32'd255);

    // Reset in the middle of a frame
    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    fv0 = fvCount;
    fe0 = feCount;
    reset = 1'b1;
    modelReset();
    #1;
    checkFields("midreset");
    checkOutput("midreset.stale", 32'(data_stale_o), 32'd1);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("midreset.pulses", (fvCount - fv0) + (feCount - fe0), 32'd0);
    checkOutput("midreset.stale2", 32'(data_stale_o), 32'd1);
    sendFrame(good, 0, "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
